ex_alu_unit: RTL

EX_ALU_UNIT -- requirements
Module: ex_alu_unit

---
 rtl/ex_alu_unit.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ex_alu_unit.sv
// rtl/ex_alu_unit.sv - EX-stage ALU with single-cycle ops and iterative shift-add multiply
// Optional feature: MUL_EARLY_EXIT_EN ends a multiply once the remaining multiplier bits are zero.
module ex_alu_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       Alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] Alu_result,
    output logic             zero,
    output logic             overflow
);
    localparam int MSB = WIDTH - 1;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   sum, diff, alu_res, prod_next, remaining;
    logic               alu_ovf, accept, last_iter;

    assign sum  = operand_a + operand_b;
    assign diff = operand_a - operand_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (Alu_control)
            OP_AND: alu_res = operand_a & operand_b;
            OP_OR:  alu_res = operand_a | operand_b;
            OP_XOR: alu_res = operand_a ^ operand_b;
            OP_NOR: alu_res = ~(operand_a | operand_b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);
            end
            OP_SLT: alu_res[0] = $signed(operand_a) < $signed(operand_b);
            default: alu_res = '0;
        endcase
    end

    // One multiplier bit per cycle: multiplicand shifts left, multiplier shifts right.
    assign prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign remaining = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (remaining == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    assign accept = in_valid && (state_q == IDLE) && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        res_d    = res_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (Alu_control == OP_MUL) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        mcand_d  = operand_a;
                        mplier_d = operand_b;
                        prod_d   = '0;
                    end else begin
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        ovf_d   = alu_ovf;
                        valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    mcand_d  = mcand_q << 1;
                    mplier_d = remaining;
                    prod_d   = prod_next;
                    if (last_iter) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        res_d   = prod_next;
                        zero_d  = (prod_next == '0);
                        ovf_d   = 1'b0;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign stall        = (state_q == MUL);
    assign result_valid = valid_q;
    assign Alu_result   = res_q;
    assign zero         = zero_q;
    assign overflow     = ovf_q;
endmodule
